// File: rtl/counter_updown_param.sv
// Parametrised loadable up/down counter with an IDLE/RUN/DONE terminal-count FSM.
// Optional feature macro: COUNTER_AUTO_RELOAD_EN (DONE becomes a one-cycle pulse followed by automatic reload).
module counter_updown_param #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = (1 << WIDTH) - 1,
    parameter int STEP      = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             inc,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [WIDTH:0]   MAX_X  = (WIDTH + 1)'(MAX_COUNT);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   count_x_s;
    logic [WIDTH:0]   sum_x_s;

`ifdef COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] x);
        if ({1'b0, x} > MAX_X) begin
            return MAX_W;
        end else begin
            return x;
        end
    endfunction

    // Widened operands so the terminal compare can never wrap.
    always_comb begin
        count_x_s = {1'b0, count_q};
        sum_x_s   = count_x_s + STEP_X;
    end

    // Next-state, next-count and registered-output decode.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef COUNTER_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            count_d = clamp(in);
            state_d = RUN;
`ifdef COUNTER_AUTO_RELOAD_EN
            reload_d = clamp(in);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (inc) begin
                        if (!dir) begin
                            if (sum_x_s >= MAX_X) begin
                                count_d = MAX_W;
                                state_d = DONE;
                            end else begin
                                count_d = sum_x_s[WIDTH-1:0];
                            end
                        end else begin
                            if (count_x_s <= STEP_X) begin
                                count_d = '0;
                                state_d = DONE;
                            end else begin
                                count_d = count_q - STEP_W;
                            end
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE: begin
`ifdef COUNTER_AUTO_RELOAD_EN
                    count_d = reload_q;
                    state_d = RUN;
`else
                    state_d = DONE;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, count and flag registers; reset beats load.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef COUNTER_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef COUNTER_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_counter_updown_param.sv
// Self-checking bench for counter_updown_param: directed scenarios plus randomized
// stimulus compared against a behavioural model on three parameter sets.
module tb_counter_updown_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] in_v = 4'd0;
    logic       inc = 1'b0;
    logic       dir = 1'b0;

    logic [2:0] c0, c1;
    logic [3:0] c2;
    logic       b0, b1, b2, d0, d1, d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // d0: W3/M7/S1, d1: W3/M7/S3, d2: W4/M7/S1
    counter_updown_param #(.WIDTH(3), .MAX_COUNT(7), .STEP(1)) u0 (
        .clock(clk), .reset(reset), .load(load), .in(in_v[2:0]), .inc(inc), .dir(dir),
        .count(c0), .busy(b0), .done(d0));
    counter_updown_param #(.WIDTH(3), .MAX_COUNT(7), .STEP(3)) u1 (
        .clock(clk), .reset(reset), .load(load), .in(in_v[2:0]), .inc(inc), .dir(dir),
        .count(c1), .busy(b1), .done(d1));
    counter_updown_param #(.WIDTH(4), .MAX_COUNT(7), .STEP(1)) u2 (
        .clock(clk), .reset(reset), .load(load), .in(in_v), .inc(inc), .dir(dir),
        .count(c2), .busy(b2), .done(d2));

    logic [3:0] cnt_a [3];
    logic [2:0] busy_a, done_a;
    assign cnt_a[0] = {1'b0, c0};
    assign cnt_a[1] = {1'b0, c1};
    assign cnt_a[2] = c2;
    assign busy_a   = {b2, b1, b0};
    assign done_a   = {d2, d1, d0};

    // Behavioural model: phase 0 idle, 1 running, 2 finished.
    typedef struct {
        int cnt;
        int phase;
        int rel;
    } mdl_t;

    mdl_t m [3];
    int   m_step [3] = '{1, 3, 1};
    int   m_w    [3] = '{3, 3, 4};
    localparam int MAXC = 7;

    function automatic mdl_t mstep(mdl_t s, int stp, int w, bit r, bit ld, int v, bit en, bit dn);
        mdl_t n = s;
        int   val = v % (1 << w);
        if (r) begin
            n.cnt = 0; n.phase = 0; n.rel = 0;
        end else if (ld) begin
            n.cnt = (val > MAXC) ? MAXC : val;
            n.rel = n.cnt;
            n.phase = 1;
        end else if (s.phase == 1 && en) begin
            if (!dn) begin
                if (s.cnt + stp >= MAXC) begin n.cnt = MAXC; n.phase = 2; end
                else n.cnt = s.cnt + stp;
            end else begin
                if (s.cnt <= stp) begin n.cnt = 0; n.phase = 2; end
                else n.cnt = s.cnt - stp;
            end
        end else if (s.phase == 2) begin
`ifdef COUNTER_AUTO_RELOAD_EN
            n.cnt = s.rel;
            n.phase = 1;
`endif
        end
        return n;
    endfunction

    task automatic tick(input bit r, input bit ld, input logic [3:0] v, input bit en, input bit dn);
        reset = r; load = ld; in_v = v; inc = en; dir = dn;
        @(posedge clk);
        for (int k = 0; k < 3; k++) m[k] = mstep(m[k], m_step[k], m_w[k], r, ld, int'(v), en, dn);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt_a[k] !== 4'd0 || busy_a[k] !== 1'b0 || done_a[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: count=%0d busy=%b done=%b, required 0/0/0", k, cnt_a[k], busy_a[k], done_a[k]);
            end
        end
    endtask

`ifndef COUNTER_AUTO_RELOAD_EN
    task automatic test_count_up();
        tick(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        checks++;
        if (c0 !== 3'd0 || b0 !== 1'b1 || d0 !== 1'b0) begin
            errors++;
            $display("FAIL up_load: count=%0d busy=%b done=%b, required 0/1/0", c0, b0, d0);
        end
        for (int k = 1; k <= 8; k++) begin
            int ec = (k > 7) ? 7 : k;
            tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            checks++;
            if (c0 !== 3'(ec) || b0 !== (k < 7) || d0 !== (k >= 7)) begin
                errors++;
                $display("FAIL up_step%0d: count=%0d busy=%b done=%b, required %0d/%b/%b", k, c0, b0, d0, ec, k < 7, k >= 7);
            end
        end
    endtask

    task automatic test_count_down();
        int exp_c [4] = '{2, 1, 0, 0};
        tick(1'b0, 1'b1, 4'd2, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            checks++;
            if (c0 !== 3'(exp_c[k]) || d0 !== (k >= 2) || b0 !== (k < 2)) begin
                errors++;
                $display("FAIL down_step%0d: count=%0d busy=%b done=%b, required %0d/%b/%b", k, c0, b0, d0, exp_c[k], k < 2, k >= 2);
            end
        end
    endtask

    task automatic test_step3();
        int exp_c [6] = '{2, 5, 7, 6, 3, 0};
        int exp_d [6] = '{0, 0, 1, 0, 0, 1};
        for (int k = 0; k < 6; k++) begin
            case (k)
                0:       tick(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
                3:       tick(1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
                1, 2:    tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
                default: tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            endcase
            checks++;
            if (c1 !== 3'(exp_c[k]) || d1 !== exp_d[k][0]) begin
                errors++;
                $display("FAIL step3_%0d: count=%0d done=%b, required %0d/%0d", k, c1, d1, exp_c[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_load_priority();
        tick(1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
        checks++;
        if (c0 !== 3'd4 || b0 !== 1'b1 || d0 !== 1'b0) begin
            errors++;
            $display("FAIL load_vs_inc: count=%0d busy=%b done=%b, required 4/1/0", c0, b0, d0);
        end
        tick(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        checks++;
        if (c2 !== 4'd7 || b2 !== 1'b1) begin
            errors++;
            $display("FAIL load_clamp: count=%0d busy=%b, required 7/1", c2, b2);
        end
    endtask

    task automatic test_reset_priority();
        tick(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        checks++;
        if (c0 !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset: count=%0d, required 3", c0);
        end
        tick(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
        checks++;
        if (c0 !== 3'd0 || b0 !== 1'b0 || d0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_vs_load: count=%0d busy=%b done=%b, required 0/0/0", c0, b0, d0);
        end
        tick(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        checks++;
        if (c0 !== 3'd1 || b0 !== 1'b1) begin
            errors++;
            $display("FAIL load_after_reset: count=%0d busy=%b, required 1/1", c0, b0);
        end
    endtask
`else
    task automatic test_auto_reload();
        int seq [3] = '{6, 7, 5};
        tick(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            checks++;
            if (c0 !== 3'(seq[k % 3]) || d0 !== (k % 3 == 1) || b0 !== (k % 3 != 1)) begin
                errors++;
                $display("FAIL auto_reload%0d: count=%0d done=%b busy=%b, required %0d/%b/%b",
                         k, c0, d0, b0, seq[k % 3], k % 3 == 1, k % 3 != 1);
            end
        end
    endtask
`endif

    task automatic test_random();
        tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            tick($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (cnt_a[k] !== 4'(m[k].cnt) || busy_a[k] !== (m[k].phase == 1) || done_a[k] !== (m[k].phase == 2)) begin
                    errors++;
                    $display("FAIL random[%0d] cyc %0d: count=%0d busy=%b done=%b, required %0d/%b/%b",
                             k, n, cnt_a[k], busy_a[k], done_a[k], m[k].cnt, m[k].phase == 1, m[k].phase == 2);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) m[k] = '{0, 0, 0};
        #2;
        test_reset();
`ifndef COUNTER_AUTO_RELOAD_EN
        test_count_up();
        test_count_down();
        test_step3();
        test_load_priority();
        test_reset_priority();
`else
        test_auto_reload();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
